smg_decoder_module: RTL and testbench

Display readback decoder: monitors the multiplexed six-digit seven-segment bus (`row` segment lines, `column` digit selects), recovers each digit's BCD value, and reassembles the displayed 20-bit binary number. It is the read end of the display path, for on-board self-check and bench verification of the scan driver. It sits beside the display driver on the same clock and taps its pins.

---
 rtl/smg_decoder_module.sv | 201 ++++++++++++++++++++
 tb/tb_smg_decoder_module.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/smg_decoder_module.sv
// -----------------------------------------------------------------------------
// smg_decoder_module
// Reads back a multiplexed six-digit seven-segment display bus. It recovers
// the BCD value of each digit and rebuilds the displayed binary number.
//
// Ports
//   clk_i     in   1  system clock
//   rst_i     in   1  asynchronous active-high reset
//   row_i     in   8  segment lines {dp,g,f,e,d,c,b,a}, active-low
//   column_i  in   6  digit selects, active-low, bit0 = least significant digit
//   num_o     out 20  binary value of the last complete frame
//   digits_o  out 24  BCD of the last frame, [3:0] = digit 0, 4'hF = undecodable
//   valid_o   out  1  one-cycle pulse when num_o/digits_o/err_o update
//   err_o     out  1  last frame had a bad segment pattern or a multi-hot select
//   stale_o   out  1  no capture for TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module smg_decoder_module #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  row_i,
  input  logic [5:0]  column_i,
  output logic [19:0] num_o,
  output logic [23:0] digits_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        stale_o
);

  localparam int DW = $clog2(STABLE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_COLLECT, S_CONVERT, S_PUBLISH} state_t;

  // Synchronizers reset to the idle (all lines inactive) level, so that
  // reset does not look like a multi-hot select.
  logic [7:0]  r_row_s1, r_row_s2;
  logic [5:0]  r_col_s1, r_col_s2;
  logic [5:0]  r_prev_s;
  logic [DW-1:0] r_dwell;
  logic [23:0] r_live;
  logic [5:0]  r_mask;
  logic        r_frame_err;
  logic [23:0] r_snap;
  logic        r_snap_err;
  logic [19:0] r_acc;
  logic [2:0]  r_step;
  logic [TW-1:0] r_tmo;
  logic [19:0] r_num;
  logic [23:0] r_digits;
  logic        r_valid;
  logic        r_err;
  state_t      r_state, w_state_next;

  logic [5:0]  w_s;
  logic [7:0]  w_g;
  logic        w_same, w_dwell_hit, w_onehot, w_cap, w_multi, w_snap_go;
  logic [3:0]  w_dec;
  logic        w_dec_bad;
  logic [23:0] w_sel;
  logic [3:0]  w_digit;
  logic [23:0] w_live_next;
  logic [5:0]  w_mask_next;

  assign w_s      = ~r_col_s2;
  assign w_g      = ~r_row_s2;
  assign w_same   = (w_s == r_prev_s);
  // The dwell counter moves from STABLE_CYC-2 to STABLE_CYC-1 exactly once
  // per dwell, which gives a single capture strobe per held select.
  assign w_dwell_hit = w_same && (r_dwell == DW'(STABLE_CYC - 2));
  assign w_onehot    = (w_s != 6'd0) && ((w_s & (w_s - 6'd1)) == 6'd0);
  assign w_cap       = w_dwell_hit && w_onehot;
  assign w_multi     = w_dwell_hit && !w_onehot && (w_s != 6'd0);
  assign w_snap_go   = (r_state == S_COLLECT) && (r_mask == 6'h3F);

  // Segment decode on active-high g, dp (bit 7) ignored.
  always_comb begin
    w_dec     = 4'hF;
    w_dec_bad = 1'b0;
    case (w_g[6:0])
      7'h3F: w_dec = 4'd0;
      7'h06: w_dec = 4'd1;
      7'h5B: w_dec = 4'd2;
      7'h4F: w_dec = 4'd3;
      7'h66: w_dec = 4'd4;
      7'h6D: w_dec = 4'd5;
      7'h7D: w_dec = 4'd6;
      7'h07: w_dec = 4'd7;
      7'h7F: w_dec = 4'd8;
      7'h6F: w_dec = 4'd9;
      default: begin
        w_dec     = 4'hF;
        w_dec_bad = 1'b1;
      end
    endcase
  end

  // Per-slot capture: a new capture wins over the snapshot clear, so the
  // first digit of the next frame is never lost.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_slot
      assign w_live_next[gi*4 +: 4] = (w_cap && w_s[gi]) ? w_dec : r_live[gi*4 +: 4];
      assign w_mask_next[gi]        = (w_cap && w_s[gi]) ? 1'b1 :
                                      (w_snap_go ? 1'b0 : r_mask[gi]);
    end
  endgenerate

  // Digit for the current MAC step; an undecodable digit counts as zero.
  assign w_sel   = r_snap >> {r_step, 2'b00};
  assign w_digit = (w_sel[3:0] == 4'hF) ? 4'd0 : w_sel[3:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COLLECT: if (w_snap_go) w_state_next = S_CONVERT;
      S_CONVERT: if (r_step == 3'd0) w_state_next = S_PUBLISH;
      S_PUBLISH: w_state_next = S_COLLECT;
      default:   w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_COLLECT;
    else       r_state <= w_state_next;
  end

  // Input path, dwell, capture and timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row_s1    <= 8'hFF;
      r_row_s2    <= 8'hFF;
      r_col_s1    <= 6'h3F;
      r_col_s2    <= 6'h3F;
      r_prev_s    <= 6'd0;
      r_dwell     <= '0;
      r_live      <= '0;
      r_mask      <= '0;
      r_frame_err <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_row_s1 <= row_i;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= column_i;
      r_col_s2 <= r_col_s1;
      r_prev_s <= w_s;
      if (!w_same)              r_dwell <= '0;
      else if (r_dwell != '1)   r_dwell <= r_dwell + DW'(1);
      r_live <= w_live_next;
      r_mask <= w_mask_next;
      if ((w_cap && w_dec_bad) || w_multi) r_frame_err <= 1'b1;
      else if (w_snap_go)                  r_frame_err <= 1'b0;
      if (w_cap)                             r_tmo <= '0;
      else if (r_tmo < TW'(TIMEOUT_CYC))     r_tmo <= r_tmo + TW'(1);
    end
  end

  // Frame snapshot, BCD-to-binary MAC and publish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_snap     <= '0;
      r_snap_err <= 1'b0;
      r_acc      <= '0;
      r_step     <= '0;
      r_num      <= '0;
      r_digits   <= '0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_COLLECT: if (w_snap_go) begin
          r_snap     <= r_live;
          r_snap_err <= r_frame_err;
          r_acc      <= '0;
          r_step     <= 3'd5;
        end
        S_CONVERT: begin
          r_acc  <= r_acc * 20'd10 + {16'd0, w_digit};
          r_step <= r_step - 3'd1;
        end
        S_PUBLISH: begin
          r_num    <= r_acc;
          r_digits <= r_snap;
          r_err    <= r_snap_err;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign num_o    = r_num;
  assign digits_o = r_digits;
  assign valid_o  = r_valid;
  assign err_o    = r_err;
  assign stale_o  = (r_tmo >= TW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_smg_decoder_module.sv
module tb_smg_decoder_module;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  row_i;
  logic [5:0]  column_i;
  logic [19:0] num_o;
  logic [23:0] digits_o;
  logic        valid_o, err_o, stale_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [19:0] num;
    logic [23:0] dig;
    logic        err;
    int          exp_cyc;   // -1: no latency check
  } exp_t;
  exp_t sb[$];

  smg_decoder_module #(.STABLE_CYC(16), .TIMEOUT_CYC(1000)) dut (
    .clk_i(clk), .rst_i(rst_i), .row_i(row_i), .column_i(column_i),
    .num_o(num_o), .digits_o(digits_o), .valid_o(valid_o),
    .err_o(err_o), .stale_o(stale_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else
      $display("[TB] ok %s = %0h", name, act);
  endtask

  // Scoreboard monitor: one line per published frame.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_valid: num=%0h digits=%0h expected no pulse", num_o, digits_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] frame num=%0h digits=%0h err=%0b at cycle %0d", num_o, digits_o, err_o, cyc);
        chk("num", 32'(num_o), 32'(e.num));
        chk("digits", 32'(digits_o), 32'(e.dig));
        chk("err", 32'(err_o), 32'(e.err));
        if (e.exp_cyc >= 0) chk("latency_cycle", cyc, e.exp_cyc);
      end
      chk("valid_single_cycle", 32'(prev_valid), 32'd0);
    end
    prev_valid = valid_o;
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0; 4'd1: seg = 8'hF9; 4'd2: seg = 8'hA4; 4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99; 4'd5: seg = 8'h92; 4'd6: seg = 8'h82; 4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80; 4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sel(input int slot, input logic [7:0] code);
    column_i = ~(6'd1 << slot);
    row_i    = code;
  endtask

  task automatic blank();
    column_i = 6'h3F;
    row_i    = 8'hFF;
  endtask

  task automatic drive(input int slot, input logic [7:0] code, input int hold);
    sel(slot, code);
    repeat (hold) step();
    blank();
    step();
  endtask

  // Scans slots 0..5; the expected frame is pushed just before the final
  // slot, whose capture lands 18 edges after it is driven and publishes 8 later.
  task automatic scan(input logic [23:0] bcd, input logic [19:0] num, input logic err,
                      input int hold, input bit lat);
    logic [23:0] v;
    v = bcd;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        exp_t e;
        e.num = num; e.dig = bcd; e.err = err;
        e.exp_cyc = lat ? cyc + 26 : -1;
        sb.push_back(e);
      end
      drive(k, seg(v[k*4 +: 4]), hold);
    end
  endtask

  initial begin
    int c;
    logic [23:0] v;
    rst_i = 1'b1;
    blank();
    repeat (3) step();
    chk("reset_num", 32'(num_o), 32'd0);
    chk("reset_digits", 32'(digits_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_stale", 32'(stale_o), 32'd0);
    rst_i = 1'b0;
    repeat (5) step();

    // Basic frame with latency check, then extremes.
    scan(24'h123456, 20'h1E240, 1'b0, 100, 1'b1);
    scan(24'h999999, 20'hF423F, 1'b0, 100, 1'b1);
    scan(24'h000000, 20'h00000, 1'b0, 100, 1'b1);

    // Undecodable slot 2, then a clean frame clears err.
    scan(24'h000F00, 20'h00000, 1'b1, 100, 1'b0);
    scan(24'h000042, 20'd42, 1'b0, 100, 1'b0);

    // Slot 3 held too briefly: no frame until it is held long enough.
    v = 24'h010203;
    begin
      exp_t e;
      e.num = 20'd10203; e.dig = v; e.err = 1'b0; e.exp_cyc = -1;
      sb.push_back(e);
    end
    for (int k = 0; k < 6; k++) drive(k, seg(v[k*4 +: 4]), (k == 3) ? 10 : 100);
    repeat (50) step();
    chk("short_dwell_no_frame", sb.size(), 32'd1);
    drive(3, seg(v[15:12]), 100);
    chk("short_dwell_frame_done", sb.size(), 32'd0);

    // Timeout: last capture at c+18, stale reaches at c+18+1000.
    c = cyc;
    sel(0, seg(4'd5));
    repeat (30) step();
    blank();
    while (cyc < c + 18 + 999) step();
    chk("stale_before_timeout", 32'(stale_o), 32'd0);
    step();
    chk("stale_at_timeout", 32'(stale_o), 32'd1);
    repeat (20) step();
    c = cyc;
    sel(1, seg(4'd6));
    while (cyc < c + 17) step();
    chk("stale_before_capture", 32'(stale_o), 32'd1);
    step();
    chk("stale_after_capture", 32'(stale_o), 32'd0);
    repeat (30) step();
    blank();
    step();

    // Reset during CONVERT aborts the frame.
    for (int k = 0; k < 5; k++) drive(k, seg(4'd7), 100);
    c = cyc;
    sel(5, seg(4'd7));
    while (cyc < c + 20) step();
    rst_i = 1'b1;
    blank();
    repeat (2) step();
    rst_i = 1'b0;
    step();
    chk("rst_conv_num", 32'(num_o), 32'd0);
    chk("rst_conv_digits", 32'(digits_o), 32'd0);
    chk("rst_conv_err", 32'(err_o), 32'd0);
    chk("rst_conv_valid", 32'(valid_o), 32'd0);
    chk("rst_conv_stale", 32'(stale_o), 32'd0);
    repeat (40) step();
    scan(24'h654321, 20'h9FBF1, 1'b0, 100, 1'b1);

    repeat (50) step();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
